// File: rtl/vga_ram_arbiter.sv
// Arbitrates the single-port VGA frame-buffer RAM between display reads (priority) and accelerator writes.
// Optional write FIFO enabled by defining VGA_ARB_WBUF_EN.
module vga_ram_arbiter #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int PIX_W     = 12,
    parameter int ADDR_W    = 17,
    parameter int MAX_STALL = 64
`ifdef VGA_ARB_WBUF_EN
    ,
    parameter int WBUF_DEPTH = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [7:0]        disp_row,
    input  logic [8:0]        disp_col,
    output logic [PIX_W-1:0]  disp_pixel,
    output logic              disp_valid,
    output logic              disp_miss,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_row,
    input  logic [8:0]        wr_col,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              err_oob,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata
);

    localparam int STALL_W = $clog2(MAX_STALL + 1);
    localparam logic [STALL_W-1:0] MAX_STALL_L = STALL_W'(MAX_STALL);
    localparam logic [8:0] IMG_H_L = 9'(IMG_H);
    localparam logic [9:0] IMG_W_L = 10'(IMG_W);

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_DISP = 2'd1,
        G_WR   = 2'd2
    } grant_t;

    typedef struct packed {
        logic             oob;
        logic [7:0]       row;
        logic [8:0]       col;
        logic [PIX_W-1:0] data;
    } wr_entry_t;

    function automatic logic is_oob(input logic [7:0] row, input logic [8:0] col);
        return ({1'b0, row} >= IMG_H_L) || ({1'b0, col} >= IMG_W_L);
    endfunction

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] row, input logic [8:0] col);
        return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    endfunction

    grant_t             grant_d, grant_q;
    logic [STALL_W-1:0] stall_d, stall_q;
    logic               miss_d, miss_q;
    logic               err_d, err_q;
    logic               rd_oob_d, rd_oob_q;
    logic [PIX_W-1:0]   pix_hold_d, pix_hold_q;
    logic               force_s;
    logic               wr_pend_s;
    logic               wr_hs_s;
    wr_entry_t          pend_s;
    wr_entry_t          in_entry_s;

    assign in_entry_s = '{oob: is_oob(wr_row, wr_col), row: wr_row, col: wr_col, data: wr_data};
    assign wr_hs_s    = wr_valid & wr_ready;

`ifdef VGA_ARB_WBUF_EN
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(WBUF_DEPTH);

    wr_entry_t        fifo_q [WBUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W:0]   cnt_d, cnt_q;
    logic             wr_ready_d, wr_ready_q;
    logic             pop_s;

    assign pop_s     = (grant_d == G_WR);
    assign wr_pend_s = (cnt_q != '0);
    assign pend_s    = fifo_q[rd_ptr_q];
    assign wr_ready  = wr_ready_q;

    // FIFO pointer/occupancy update; ready looks at next occupancy so a pop while full re-opens it.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        if (wr_hs_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        cnt_d      = cnt_q + (PTR_W + 1)'(wr_hs_s) - (PTR_W + 1)'(pop_s);
        wr_ready_d = (cnt_d != DEPTH_L);
    end

    // FIFO storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            if (wr_hs_s) begin
                fifo_q[wr_ptr_q] <= in_entry_s;
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            wr_ready_q <= wr_ready_d;
        end
    end
`else
    assign wr_pend_s = wr_valid;
    assign pend_s    = in_entry_s;
    assign wr_ready  = rst_n & (~disp_req | force_s);
`endif

    // Force only bites while a write is actually waiting, so a read is never dropped for nothing.
    assign force_s = (stall_q == MAX_STALL_L) & wr_pend_s;

    // Grant decision plus starvation counter, miss flag, sticky error and read bookkeeping.
    always_comb begin
        grant_d    = G_IDLE;
        stall_d    = '0;
        miss_d     = 1'b0;
        err_d      = err_q;
        rd_oob_d   = is_oob(disp_row, disp_col);
        pix_hold_d = pix_hold_q;
        if (disp_req && !force_s) begin
            grant_d = G_DISP;
        end else if (wr_pend_s) begin
            grant_d = G_WR;
        end else begin
            grant_d = G_IDLE;
        end
        if ((grant_d == G_DISP) && wr_pend_s) begin
            stall_d = (stall_q == MAX_STALL_L) ? stall_q : stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = '0;
        end
        miss_d = (grant_d == G_WR) & disp_req;
        if (wr_hs_s && in_entry_s.oob) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if (grant_q == G_DISP) begin
            pix_hold_d = disp_pixel;
        end else begin
            pix_hold_d = pix_hold_q;
        end
    end

    // RAM port is driven straight from the current-cycle grant; out-of-range accesses are suppressed.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (grant_d)
            G_DISP: begin
                ram_en   = ~rd_oob_d;
                ram_we   = 1'b0;
                ram_addr = rd_oob_d ? '0 : pix_addr(disp_row, disp_col);
            end
            G_WR: begin
                ram_en    = ~pend_s.oob;
                ram_we    = ~pend_s.oob;
                ram_addr  = pend_s.oob ? '0 : pix_addr(pend_s.row, pend_s.col);
                ram_wdata = pend_s.data;
            end
            default: begin
                ram_en    = 1'b0;
                ram_we    = 1'b0;
                ram_addr  = '0;
                ram_wdata = '0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= G_IDLE;
            stall_q    <= '0;
            miss_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_oob_q   <= 1'b0;
            pix_hold_q <= '0;
        end else begin
            grant_q    <= grant_d;
            stall_q    <= stall_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            rd_oob_q   <= rd_oob_d;
            pix_hold_q <= pix_hold_d;
        end
    end

    // RAM data arrives one cycle after the grant, so the pixel is muxed in that cycle and held afterwards.
    assign disp_valid = (grant_q == G_DISP);
    assign disp_pixel = (grant_q == G_DISP) ? (rd_oob_q ? '0 : ram_rdata) : pix_hold_q;
    assign disp_miss  = miss_q;
    assign err_oob    = err_q;

endmodule
